// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a sticky frame-complete flag; `define UART_PARITY_EN to
// insert an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps
module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  clear,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_interrupt
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                r_state;
    logic [BAUD_W-1:0]     r_baud_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx_out;
    logic                  r_tx_busy;
    logic                  r_tx_int;

    state_t                w_state_nxt;
    logic [BAUD_W-1:0]     w_baud_nxt;
    logic [BIT_W-1:0]      w_bit_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_tx_out_nxt;
    logic                  w_busy_nxt;
    logic                  w_done;
    logic                  w_baud_end;

`ifdef UART_PARITY_EN
    logic r_parity;
    logic w_parity_nxt;
`endif

    assign w_baud_end = (r_baud_cnt == BAUD_LAST);
    assign w_shifted  = r_shift >> 1;

    // Next-state logic; every output is computed one cycle ahead and registered.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_tx_out_nxt = r_tx_out;
        w_busy_nxt   = r_tx_busy;
        w_done       = 1'b0;
`ifdef UART_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx_out_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
                if (tx_start) begin
                    w_state_nxt  = S_START;
                    w_baud_nxt   = '0;
                    w_bit_nxt    = '0;
                    w_shift_nxt  = tx_data;
                    w_tx_out_nxt = 1'b0;
                    w_busy_nxt   = 1'b1;
`ifdef UART_PARITY_EN
                    w_parity_nxt = ^tx_data;
`endif
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_nxt  = S_DATA;
                    w_baud_nxt   = '0;
                    w_bit_nxt    = '0;
                    w_tx_out_nxt = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = w_shifted;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_nxt = '0;
`ifdef UART_PARITY_EN
                        w_state_nxt  = S_PARITY;
                        w_tx_out_nxt = r_parity;
`else
                        w_state_nxt  = S_STOP;
                        w_tx_out_nxt = 1'b1;
`endif
                    end else begin
                        w_bit_nxt    = r_bit_cnt + BIT_W'(1);
                        w_tx_out_nxt = w_shifted[0];
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_baud_end) begin
                    w_state_nxt  = S_STOP;
                    w_baud_nxt   = '0;
                    w_tx_out_nxt = 1'b1;
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_baud_end) begin
                    w_state_nxt  = S_IDLE;
                    w_baud_nxt   = '0;
                    w_tx_out_nxt = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_done       = 1'b1;
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_baud_nxt   = '0;
                w_bit_nxt    = '0;
                w_tx_out_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx_out   <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx_out   <= w_tx_out_nxt;
            r_tx_busy  <= w_busy_nxt;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    // Completion wins over clear so a flag raised on the same edge is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_int <= 1'b0;
        end else if (w_done) begin
            r_tx_int <= 1'b1;
        end else if (clear) begin
            r_tx_int <= 1'b0;
        end
    end

    assign tx_out       = r_tx_out;
    assign tx_busy      = r_tx_busy;
    assign tx_interrupt = r_tx_int;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=10; table vectors, hand-written corner
// sequences and random frames against a bit-list reference model.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       clear = 1'b0;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_interrupt;

    int checks   = 0;
    int failures = 0;

    uart_tx #(.CLK_FREQ(1000), .BAUD(100), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data), .clear(clear),
        .tx_out(tx_out), .tx_busy(tx_busy), .tx_interrupt(tx_interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line bit list, slot 0 first: start, LSB..MSB, optional even parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] d, input logic [10:0] exp_bits,
                             input int poke_at, input bit clr_at_end);
        tx_data  = d;
        tx_start = 1'b1;
        clear    = 1'b1;
        tick();
        tx_start = 1'b0;
        clear    = 1'b0;
        tx_data  = ~d;
        for (int t = 0; t < FRAME; t++) begin
            check({tag, " line"}, 32'(tx_out), 32'(exp_bits[t / CPB]));
            check({tag, " busy"}, 32'(tx_busy), 32'd1);
            check({tag, " irq_mid"}, 32'(tx_interrupt), 32'd0);
            if (t == poke_at) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end else begin
                tx_start = 1'b0;
            end
            clear = (clr_at_end && t == FRAME - 1);
            tick();
        end
        tx_start = 1'b0;
        clear    = 1'b0;
        check({tag, " end_busy"}, 32'(tx_busy), 32'd0);
        check({tag, " end_irq"}, 32'(tx_interrupt), 32'd1);
        check({tag, " end_line"}, 32'(tx_out), 32'd1);
    endtask

    initial begin
        vec_t        tbl[6];
        logic [10:0] exp_f;
        logic [7:0]  d;
        int          gap;

        tbl[0] = '{data: 8'hA5, par: 1'b0};
        tbl[1] = '{data: 8'h07, par: 1'b1};
        tbl[2] = '{data: 8'h03, par: 1'b0};
        tbl[3] = '{data: 8'hFF, par: 1'b0};
        tbl[4] = '{data: 8'h00, par: 1'b0};
        tbl[5] = '{data: 8'h01, par: 1'b1};

        // Reset values, visible without a clock edge
        #2 rst = 1'b0;
        #1;
        check("rst_line", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_irq", 32'(tx_interrupt), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            check("idle_line", 32'(tx_out), 32'd1);
            check("idle_busy", 32'(tx_busy), 32'd0);
            check("idle_irq", 32'(tx_interrupt), 32'd0);
            tick();
        end

        // Table vectors, sent back to back
        for (int i = 0; i < 6; i++) begin
`ifdef UART_PARITY_EN
            exp_f = {1'b1, tbl[i].par, tbl[i].data, 1'b0};
`else
            exp_f = {1'b1, 1'b1, tbl[i].data, 1'b0};
`endif
            run_frame("table", tbl[i].data, exp_f, -1, 1'b0);
        end

        // Clear pulse, clear on an already-clear flag, clear on the completion edge
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_irq", 32'(tx_interrupt), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_noop_irq", 32'(tx_interrupt), 32'd0);
        check("clear_noop_busy", 32'(tx_busy), 32'd0);
        run_frame("set_vs_clear", 8'h5A, model_frame(8'h5A), -1, 1'b1);
        tick();
        tick();
        check("irq_hold", 32'(tx_interrupt), 32'd1);

        // Start while busy is ignored, then a start in the first idle cycle is taken
        run_frame("busy_ignore", 8'h3C, model_frame(8'h3C), 30, 1'b0);
        run_frame("back2back", 8'h00, model_frame(8'h00), -1, 1'b0);

        // Asynchronous reset at cycle 45 of a frame
        tx_data  = 8'h81;
        tx_start = 1'b1;
        clear    = 1'b1;
        tick();
        tx_start = 1'b0;
        clear    = 1'b0;
        repeat (44) tick();
        check("pre_abort_line", 32'(tx_out), 32'd0);
        check("pre_abort_busy", 32'(tx_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_line", 32'(tx_out), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_irq", 32'(tx_interrupt), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("post_abort_busy", 32'(tx_busy), 32'd0);
        check("post_abort_irq", 32'(tx_interrupt), 32'd0);
        run_frame("after_reset", 8'h81, model_frame(8'h81), -1, 1'b0);

        // Random data with random idle gaps
        for (int n = 0; n < 20; n++) begin
            d   = 8'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                check("gap_line", 32'(tx_out), 32'd1);
                check("gap_busy", 32'(tx_busy), 32'd0);
                tick();
            end
            run_frame("random", d, model_frame(d), -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
